conv_layer_controller: RTL
==========================

// Module: conv_layer_controller
// PURPOSE
//   Sequences one full image pass through convolutional_layer. Generates pixel
//   read addresses for the input frame buffer and drives the layer's clk_en.
//   Tags each layer output with its (channel,row,col) and asserts out_valid only
//   for windows lying wholly inside one channel's image. Sits between the frame
//   buffer and the layer; downstream back-pressure freezes the whole pipeline.
// PARAMETERS
//   IMAGE_SIZE    64  pixels per row/column (square image)
//   FILTER_SIZE   2   conv window edge; first FILTER_SIZE-1 rows/cols masked
//   D_CHANNELS    1   input channels streamed back-to-back, channel 0 first
//   PIPE_LATENCY  1   layer cycles from clk_en'd input to matching output_data
//   ADDR_WIDTH    12  rd_addr width; must hold IMAGE_SIZE*IMAGE_SIZE-1
//   CH_WIDTH      1   channel_sel width; must hold D_CHANNELS-1
// PORTS
//   clk           in   1           system clock, all state on rising edge
//   rst           in   1           asynchronous, active-high reset
//   start         in   1           1-cycle pulse; begins a pass when idle
//   stall         in   1           downstream not ready; freezes everything
//   busy          out  1           high from accepted start until done
//   done          out  1           1-cycle pulse when last output has emerged
//   rd_en         out  1           frame buffer read strobe
//   rd_addr       out  ADDR_WIDTH  pixel index within channel, row-major
//   channel_sel   out  CH_WIDTH    channel being read
//   layer_clk_en  out  1           clk_en to convolutional_layer
//   out_valid     out  1           layer output_data this cycle is a real window
//   out_row       out  ADDR_WIDTH  row of window's bottom-right pixel
//   out_col       out  ADDR_WIDTH  col of window's bottom-right pixel
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; counters and tag pipe cleared. Reset
//     mid-pass aborts immediately; no done pulse is produced.
//   FSM: IDLE -(start)-> STREAM -(last pixel of last channel read)-> DRAIN
//     -(drain count reached)-> DONE -> IDLE. start ignored outside IDLE.
//   STREAM, stall=0: rd_en=1, rd_addr=p, channel_sel=k; p increments each cycle;
//     p wraps IMAGE_SIZE^2-1 -> 0 with k+1 (no bubble between channels).
//   stall=1 in any non-IDLE state: rd_en=0, layer_clk_en=0, counters, tag pipe
//     and drain counter hold; out_valid forced 0. Stall in IDLE/DONE ignored.
//   Frame buffer read latency is 1: pixel p read in cycle t is on input_data in
//     t+1. layer_clk_en = !stall in STREAM and DRAIN, else 0.
//   Tag pipe: 1+PIPE_LATENCY stages carrying {v,row,col}; stage 0 loads v=rd_en,
//     row=p/IMAGE_SIZE, col=p%IMAGE_SIZE (kept as separate row/col counters).
//     Latency read-to-out_valid = 1+PIPE_LATENCY unstalled cycles.
//   out_valid = last stage v && row>=FILTER_SIZE-1 && col>=FILTER_SIZE-1
//     && !stall. Masks row-wrap windows and windows straddling a channel edge.
//   DRAIN: counts 1+PIPE_LATENCY unstalled cycles, rd_en=0, then DONE.
//   DONE: done=1, busy=0 for exactly one cycle; start that cycle is ignored.
//   busy=1 in STREAM and DRAIN only.
//   Per channel exactly (IMAGE_SIZE-FILTER_SIZE+1)^2 out_valid pulses.
// TESTING
//   T1 IMAGE_SIZE=4,F=2,D_CH=1,LAT=1: start, no stall -> rd_addr 0..15 on
//      16 consecutive cycles; 9 out_valid pulses, first tagged (1,1), last
//      (3,3); done 19 cycles after start accepted; busy high 18 cycles.
//   T2 Same, stall held 3 cycles mid-stream -> rd_addr, tags, layer_clk_en
//      freeze; same 9 tags in order; done delayed by exactly 3 cycles.
//   T3 D_CHANNELS=2 -> channel_sel 0 for 16 reads then 1 for 16, no gap; 18
//      out_valid total; no valid with row 0 or col 0 after channel switch.
//   T4 start pulsed while busy and in DONE cycle -> ignored; one done pulse.
//   T5 rst asserted mid-STREAM (async, between edges) -> outputs 0
//      immediately, IDLE; no done; next start restarts at rd_addr 0.
//   T6 Full config 64/2/1/1 against convolutional_layer with frame buffer
//      model -> every out_valid output_data equals sum of 2x2 window at tag.

Source files
------------

// File: rtl/conv_layer_controller.sv
// Sequencer for one image pass through convolutional_layer.
// It generates row-major pixel read addresses for the frame buffer and drives the
// layer's clock enable. A small tag pipe follows each pixel through the frame
// buffer and layer latency. Each layer output is then marked valid or masked.
// Downstream back-pressure (stall) freezes the whole pipeline.
module conv_layer_controller #(
  parameter int unsigned IMAGE_SIZE   = 64,
  parameter int unsigned FILTER_SIZE  = 2,
  parameter int unsigned D_CHANNELS   = 1,
  parameter int unsigned PIPE_LATENCY = 1,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned CH_WIDTH     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [CH_WIDTH-1:0]   channel_sel,
  output logic                  layer_clk_en,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_row,
  output logic [ADDR_WIDTH-1:0] out_col
);

  // One stage for the frame-buffer read, then one per layer pipeline cycle.
  localparam int unsigned Stages    = 1 + PIPE_LATENCY;
  localparam int unsigned LastStage = PIPE_LATENCY;
  localparam int unsigned DrainW    = $clog2(Stages + 1);

  localparam logic [ADDR_WIDTH-1:0] PixLast   = ADDR_WIDTH'(IMAGE_SIZE * IMAGE_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ColLast   = ADDR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] EdgeMin   = ADDR_WIDTH'(FILTER_SIZE - 1);
  localparam logic [CH_WIDTH-1:0]   ChLast    = CH_WIDTH'(D_CHANNELS - 1);
  localparam logic [DrainW-1:0]     DrainLast = DrainW'(PIPE_LATENCY);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] pix_q, pix_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [CH_WIDTH-1:0]   ch_q, ch_d;
  logic [DrainW-1:0]     drain_q, drain_d;

  logic                  tag_v_q   [Stages];
  logic [ADDR_WIDTH-1:0] tag_row_q [Stages];
  logic [ADDR_WIDTH-1:0] tag_col_q [Stages];

  logic running;
  logic advance;

  assign running = (state_q == StStream) || (state_q == StDrain);
  assign advance = running && !stall;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pix_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ch_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ch_q    <= ch_d;
      drain_q <= drain_d;
    end
  end

  // Next-state, address counters and control strobes.
  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    row_d        = row_q;
    col_d        = col_q;
    ch_d         = ch_q;
    drain_d      = drain_q;
    busy         = 1'b0;
    done         = 1'b0;
    rd_en        = 1'b0;
    layer_clk_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStream;
        end
      end

      StStream: begin
        busy         = 1'b1;
        layer_clk_en = !stall;
        if (!stall) begin
          rd_en = 1'b1;
          if (col_q == ColLast) begin
            col_d = '0;
            if (pix_q == PixLast) begin
              // Channel boundary: the next channel starts on the very next cycle.
              pix_d = '0;
              row_d = '0;
              if (ch_q == ChLast) begin
                ch_d    = '0;
                drain_d = '0;
                state_d = StDrain;
              end else begin
                ch_d = ch_q + CH_WIDTH'(1);
              end
            end else begin
              pix_d = pix_q + ADDR_WIDTH'(1);
              row_d = row_q + ADDR_WIDTH'(1);
            end
          end else begin
            pix_d = pix_q + ADDR_WIDTH'(1);
            col_d = col_q + ADDR_WIDTH'(1);
          end
        end
      end

      StDrain: begin
        // Keep the layer clocked until the last pixel's result has emerged.
        busy         = 1'b1;
        layer_clk_en = !stall;
        if (!stall) begin
          if (drain_q == DrainLast) begin
            state_d = StDone;
          end else begin
            drain_d = drain_q + DrainW'(1);
          end
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Tag pipe: tracks each pixel through the frame-buffer and layer latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Stages; i++) begin
        tag_v_q[i]   <= 1'b0;
        tag_row_q[i] <= '0;
        tag_col_q[i] <= '0;
      end
    end else if (advance) begin
      tag_v_q[0]   <= rd_en;
      tag_row_q[0] <= row_q;
      tag_col_q[0] <= col_q;
      for (int unsigned i = 1; i < Stages; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_row_q[i] <= tag_row_q[i-1];
        tag_col_q[i] <= tag_col_q[i-1];
      end
    end
  end

  // Windows whose bottom-right pixel is in the first FILTER_SIZE-1 rows or columns
  // would wrap a row or straddle a channel edge, so they are masked.
  always_comb begin
    out_valid = running && !stall && tag_v_q[LastStage] &&
                (tag_row_q[LastStage] >= EdgeMin) && (tag_col_q[LastStage] >= EdgeMin);
  end

  assign out_row     = tag_row_q[LastStage];
  assign out_col     = tag_col_q[LastStage];
  assign rd_addr     = pix_q;
  assign channel_sel = ch_q;

endmodule
